io_write_arbiter: RTL
=====================

Name: io_write_arbiter

Overview:
- Shares the single memory-mapped output-port write path (write_io_enable / addr / datain into the output-port register bank) between two requesters: requester 0 is the CPU store path, requester 1 is the debug/loader master.
- Each requester posts writes into a one-entry slot through a valid/ready handshake.
- A round-robin scheduler drains the slots, one write per cycle, onto registered outputs feeding the port bank.
- Addresses outside the port window are rejected with an error pulse; no port write is issued for them.

Parameters:
- DATA_W, 32, width of data and address buses.
- PORT_BASE, 6'b100000, value of addr[7:2] that selects port 0.
- NPORTS, 3, number of valid ports; window is PORT_BASE .. PORT_BASE+NPORTS-1 on addr[7:2].
- CNT_W, 16, width of the accepted-write counter.

Ports:
- io_clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- r0_valid  in  1  requester 0 write request.
- r0_ready  out  1  requester 0 slot empty; transfer on valid&&ready.
- r0_addr  in  DATA_W  requester 0 byte address.
- r0_data  in  DATA_W  requester 0 write data.
- r1_valid, r1_ready, r1_addr, r1_data: same as requester 0, for requester 1.
- io_addr  out  DATA_W  address to port bank.
- io_datain  out  DATA_W  data to port bank.
- write_io_enable  out  1  one-cycle write strobe to port bank.
- err_pulse  out  1  one-cycle pulse: out-of-window write dropped.
- err_src  out  1  requester index of the last error, held until the next error.
- wr_count  out  CNT_W  number of port writes issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, effective immediately):
  - both slots EMPTY, rr pointer = 0.
  - io_addr = 0, io_datain = 0, write_io_enable = 0.
  - err_pulse = 0, err_src = 0, wr_count = 0.
- Reset asserted mid-operation discards buffered writes; no strobe occurs while reset is high or in the cycle after its release.
- Slot per requester, two states:
  - EMPTY -> FULL on valid&&ready at the edge; addr and data are captured.
  - FULL -> EMPTY at the edge where the slot is granted.
  - rN_ready = (slot EMPTY), registered; no combinational valid-to-ready path.
  - A slot granted at edge E shows ready at E+1 and accepts at the earliest at edge E+1. Per-requester peak rate is one write per 2 cycles; aggregate peak is 1/cycle.
- Arbitration, evaluated each cycle on slot states:
  - Only slot 0 FULL: grant 0.
  - Only slot 1 FULL: grant 1.
  - Both FULL: grant the slot != rr. rr is the last granted index; it updates on every grant, including error grants.
  - Neither FULL: no grant, write_io_enable = 0.
- Issue (registered, same edge as the grant):
  - If the granted addr[7:2] is in the window: write_io_enable = 1, io_addr/io_datain = slot contents, wr_count += 1.
  - Otherwise: write_io_enable = 0, err_pulse = 1, err_src = granted index; io_addr/io_datain keep their previous values and wr_count is unchanged.
- io_addr/io_datain hold their last issued values when idle.
- Latency: accept at edge N -> strobe visible after edge N+1 (if uncontested) -> port register updates at edge N+2. A contested write may wait exactly one extra cycle; starvation is impossible.
- Ordering: per requester, writes reach the port bank in acceptance order. Across requesters, order follows grant order.
- addr[1:0] and addr[31:8] are ignored for decode and passed through unchanged on io_addr.
- wr_count wraps from 2^CNT_W-1 to 0 without any flag.

Decomposition:
- Shared package io_pkg holds:
  - PORT_BASE, NPORTS, and per-port index constants (PORT0_SEL = 6'b100000, PORT1_SEL = 6'b100001, PORT2_SEL = 6'b100010).
  - REQ_CPU = 0, REQ_DBG = 1.
  - An in_window(addr) function.
- Sub-module io_req_slot: single-entry valid/ready buffer with full flag, captured addr/data, and a pop input; instantiated twice.
- Arbiter, issue registers and counter live in io_write_arbiter.

Test Plan:
- Reset, then r0 writes addr 0x80 / data 0x12345678 at edge 1 -> write_io_enable=1 with io_addr=0x80, io_datain=0x12345678 after edge 2; wr_count=1; r0_ready low after edge 1, high after edge 2.
- Both slots FULL in the same cycle with rr=0 (r0 at 0x84/0xA, r1 at 0x88/0xB) -> r1 issued first, r0 the next cycle; wr_count +2; rr ends at 0.
- Back-to-back streams on both requesters for 20 cycles -> strobes alternate 1,0,1,0, one per cycle, no gap after the first, and each requester's data arrives in its own order.
- r1 writes addr 0x8C (addr[7:2]=100011) -> err_pulse for one cycle, err_src=1, write_io_enable stays 0, wr_count unchanged, slot freed.
- Preload wr_count to 0xFFFF via 65535 writes (or a force), then one valid write -> wr_count=0x0000.
- Assert reset while both slots are FULL and mid-issue -> all outputs 0 immediately (asynchronous), no strobe after release until a new request is accepted.

Source files
------------

// File: rtl/io_pkg.sv
// Purpose : shared constants and decode helper for the output-port write path.
// Latency : n/a (package, no logic).
// Backpr. : n/a.
// Contents: port window base/size, per-port select codes, requester indices,
//           in_window() decode on addr[7:2].
package io_pkg;

  // addr[7:2] value selecting port 0; the window is PORT_BASE .. PORT_BASE+NPORTS-1
  localparam logic [5:0]  PORT_BASE = 6'b100000;
  localparam int unsigned NPORTS    = 3;

  localparam logic [5:0]  PORT0_SEL = 6'b100000;
  localparam logic [5:0]  PORT1_SEL = 6'b100001;
  localparam logic [5:0]  PORT2_SEL = 6'b100010;

  // Requester indices: CPU store path and debug/loader master
  localparam logic        REQ_CPU   = 1'b0;
  localparam logic        REQ_DBG   = 1'b1;

  // True when the word-select field addr[7:2] falls inside the port window.
  // Done in 7 bits so base+nports cannot wrap around the 6-bit field.
  function automatic logic in_window(input logic [5:0]  sel,
                                     input logic [5:0]  base,
                                     input int unsigned nports);
    logic [6:0] s;
    logic [6:0] lo;
    logic [6:0] hi;
    s  = {1'b0, sel};
    lo = {1'b0, base};
    hi = lo + 7'(nports);
    return (s >= lo) && (s < hi);
  endfunction

endpackage

// File: rtl/io_req_slot.sv
// Purpose : one-entry write buffer (addr+data) between a requester and the arbiter.
// Latency : captured at the accepting edge; visible as full one cycle later.
// Backpr. : ready is the registered EMPTY state; no combinational valid->ready path.
// Ports   : io_clk/reset; valid/ready/addr/data from the requester;
//           pop from the arbiter (grant); full/slot_addr/slot_data to the arbiter.
module io_req_slot #(
  parameter int DATA_W = 32
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic              full,
  output logic [DATA_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  localparam logic [0:0] SLOT_EMPTY = 1'b0;
  localparam logic [0:0] SLOT_FULL  = 1'b1;

  logic [0:0] state;

  assign full  = (state == SLOT_FULL);
  assign ready = (state == SLOT_EMPTY);

  // A slot is only ever filled while EMPTY and only ever popped while FULL,
  // so fill and pop can never collide on the same edge.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state     <= SLOT_EMPTY;
      slot_addr <= '0;
      slot_data <= '0;
    end else begin
      case (state)
        SLOT_EMPTY: begin
          if (valid) begin
            state     <= SLOT_FULL;
            slot_addr <= addr;
            slot_data <= data;
          end
        end
        SLOT_FULL: begin
          if (pop) begin
            state <= SLOT_EMPTY;
          end
        end
        default: state <= SLOT_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/io_write_arbiter.sv
// Purpose : shares the output-port write path between CPU (req 0) and debug (req 1).
// Latency : accept at edge N -> strobe after N+1 (uncontested, +1 cycle if contested).
// Backpr. : per-requester one-entry slot; rN_ready low while that slot holds a write.
// Ports   : io_clk/reset; rN_valid/rN_ready/rN_addr/rN_data per requester;
//           io_addr/io_datain/write_io_enable to the port bank;
//           err_pulse/err_src for dropped out-of-window writes; wr_count of issued writes.
module io_write_arbiter
  import io_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [5:0]  PORT_BASE = io_pkg::PORT_BASE,
  parameter int unsigned NPORTS    = io_pkg::NPORTS,
  parameter int          CNT_W     = 16
) (
  input  logic              io_clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [DATA_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [DATA_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] io_addr,
  output logic [DATA_W-1:0] io_datain,
  output logic              write_io_enable,
  output logic              err_pulse,
  output logic              err_src,
  output logic [CNT_W-1:0]  wr_count
);

  logic              full0, full1;
  logic [DATA_W-1:0] slot0_addr, slot0_data;
  logic [DATA_W-1:0] slot1_addr, slot1_data;

  logic              rr;          // index of the most recent grant
  logic              gnt_vld;
  logic              gnt_idx;
  logic              pop0, pop1;
  logic [DATA_W-1:0] gnt_addr, gnt_data;
  logic              gnt_ok;

  io_req_slot #(.DATA_W(DATA_W)) u_slot0 (
    .io_clk    (io_clk),
    .reset     (reset),
    .valid     (r0_valid),
    .ready     (r0_ready),
    .addr      (r0_addr),
    .data      (r0_data),
    .pop       (pop0),
    .full      (full0),
    .slot_addr (slot0_addr),
    .slot_data (slot0_data)
  );

  io_req_slot #(.DATA_W(DATA_W)) u_slot1 (
    .io_clk    (io_clk),
    .reset     (reset),
    .valid     (r1_valid),
    .ready     (r1_ready),
    .addr      (r1_addr),
    .data      (r1_data),
    .pop       (pop1),
    .full      (full1),
    .slot_addr (slot1_addr),
    .slot_data (slot1_data)
  );

  // Round robin over two slots: under contention the winner is simply the
  // slot that did not win last time, so a waiting slot is served next cycle.
  always_comb begin
    gnt_vld  = full0 | full1;
    gnt_idx  = (full0 && full1) ? ~rr : full1;
    pop0     = gnt_vld && (gnt_idx == REQ_CPU);
    pop1     = gnt_vld && (gnt_idx == REQ_DBG);
    gnt_addr = (gnt_idx == REQ_DBG) ? slot1_addr : slot0_addr;
    gnt_data = (gnt_idx == REQ_DBG) ? slot1_data : slot0_data;
    gnt_ok   = in_window(gnt_addr[7:2], PORT_BASE, NPORTS);
  end

  // Issue stage. Error grants still consume the slot and advance rr, but
  // leave io_addr/io_datain and the counter untouched.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      rr              <= REQ_CPU;
      io_addr         <= '0;
      io_datain       <= '0;
      write_io_enable <= 1'b0;
      err_pulse       <= 1'b0;
      err_src         <= 1'b0;
      wr_count        <= '0;
    end else begin
      write_io_enable <= 1'b0;
      err_pulse       <= 1'b0;
      if (gnt_vld) begin
        rr <= gnt_idx;
        if (gnt_ok) begin
          write_io_enable <= 1'b1;
          io_addr         <= gnt_addr;
          io_datain       <= gnt_data;
          wr_count        <= wr_count + CNT_W'(1);
        end else begin
          err_pulse <= 1'b1;
          err_src   <= gnt_idx;
        end
      end
    end
  end

endmodule
